bar_painter: RTL

Frame-buffer writer for the 160x120 RGB111 game display: owns the write port of the dual-port pixel buffer, whose read port is scanned by the VGA path. After reset it paints the background and a horizontal player bar. It then moves the bar left or right on a fixed movement tick according to two button inputs, erasing the old bar rectangle and drawing the new one one pixel per clock. Buffer layout is row-major: address = x + y*SCREEN_X. The read side must use the same mapping.

---
 rtl/bar_painter_if.sv | 22 ++
 rtl/bar_painter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_painter_if.sv
// Pixel-buffer write port driven by bar_painter.
// The master drives one write per clock while px_wr is high.
interface bar_painter_if #(
   parameter int AW = 15,
   parameter int DW = 3
);
   logic [AW-1:0] mem_px_addr;
   logic [DW-1:0] mem_px_data;
   logic          px_wr;

   modport master (
      output mem_px_addr,
      output mem_px_data,
      output px_wr
   );

   modport slave (
      input  mem_px_addr,
      input  mem_px_data,
      input  px_wr
   );
endinterface

// File: rtl/bar_painter.sv
// bar_painter: frame-buffer writer for the 160x120 RGB111 display.
// After reset it paints the background and the player bar, then moves the bar
// left/right on each movement tick from two synchronized buttons, erasing the
// old rectangle and drawing the new one at one pixel per clock.
// Buffer layout is row-major: address = x + y*SCREEN_X.
//
// Optional feature macro: BAR_PAINTER_CLEAR_EN
//   defined     - after reset the whole buffer is cleared, then the bar is drawn
//   not defined - the clear pass and its linear counter are absent; after reset
//                 only the bar is drawn over the preloaded background image
//
// state  | meaning
// CLEAR  | write BG_COLOR to every buffer address, ascending
// ERASE  | write BG_COLOR over the bar rectangle at old_x
// DRAW   | write BAR_COLOR over the bar rectangle at bar_x
// IDLE   | no writes; wait for a tick with a legal move
//
// Outputs are registered and show the pixel selected in the previous cycle's
// state, so the IDLE->ERASE transition also issues ERASE pixel 0 to make the
// first erase write land one cycle after the tick.
module bar_painter #(
   parameter int            SCREEN_X  = 160,
   parameter int            SCREEN_Y  = 120,
   parameter int            AW        = 15,
   parameter int            DW        = 3,
   parameter int            BAR_W     = 16,
   parameter int            BAR_H     = 4,
   parameter int            BAR_Y     = 112,
   parameter int            STEP      = 2,
   parameter int            TICK_DIV  = 416667,
   parameter logic [DW-1:0] BG_COLOR  = 3'b000,
   parameter logic [DW-1:0] BAR_COLOR = 3'b010
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in1,
   input  logic          in2,
   bar_painter_if.master px_if,
   output logic          busy
);

   localparam int PXW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int PYW = (BAR_H > 1) ? $clog2(BAR_H) : 1;
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PXW-1:0] PX_LAST   = PXW'(BAR_W - 1);
   localparam logic [PYW-1:0] PY_LAST   = PYW'(BAR_H - 1);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [8:0]     X_MAX9    = 9'(SCREEN_X - BAR_W);
   localparam logic [8:0]     STEP9     = 9'(STEP);
   localparam logic [7:0]     X_RST     = 8'((SCREEN_X - BAR_W) / 2);

`ifdef BAR_PAINTER_CLEAR_EN
   localparam int            LW       = $clog2(SCREEN_X * SCREEN_Y);
   localparam logic [LW-1:0] LIN_LAST = LW'(SCREEN_X * SCREEN_Y - 1);

   typedef enum logic [1:0] {ST_CLEAR, ST_ERASE, ST_DRAW, ST_IDLE} state_t;
   localparam state_t ST_START = ST_CLEAR;
`else
   typedef enum logic [1:0] {ST_ERASE, ST_DRAW, ST_IDLE} state_t;
   localparam state_t ST_START = ST_DRAW;
`endif

   state_t         state_q, state_d;
   logic [7:0]     bar_x_q, bar_x_d;
   logic [7:0]     old_x_q, old_x_d;
   logic [PXW-1:0] px_q, px_d;
   logic [PYW-1:0] py_q, py_d;
`ifdef BAR_PAINTER_CLEAR_EN
   logic [LW-1:0]  lin_q, lin_d;
`endif

   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  data_q, data_d;
   logic           wr_q, wr_d;
   logic           busy_q, busy_d;

   logic           in1_m_q, in1_s_q;
   logic           in2_m_q, in2_s_q;

   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic           tick_p;

   logic [8:0]     right_x9, left_x9;
   logic [7:0]     new_x;

   logic           rect_last;
   logic [PXW-1:0] px_adv;
   logic [PYW-1:0] py_adv;

   function automatic logic [AW-1:0] rect_addr(input logic [7:0]     x,
                                                input logic [PXW-1:0] px,
                                                input logic [PYW-1:0] py);
      return (AW'(BAR_Y) + AW'(py)) * AW'(SCREEN_X) + AW'(x) + AW'(px);
   endfunction

   // Two-flop synchronizers for the asynchronous buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         in1_m_q <= 1'b0;
         in1_s_q <= 1'b0;
         in2_m_q <= 1'b0;
         in2_s_q <= 1'b0;
      end else begin
         in1_m_q <= in1;
         in1_s_q <= in1_m_q;
         in2_m_q <= in2;
         in2_s_q <= in2_m_q;
      end
   end

   assign tick_p     = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick_p ? '0 : tick_cnt_q + TW'(1);

   // Free-running movement tick counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // Candidate bar position from the buttons, clamped to the screen.
   always_comb begin
      right_x9 = {1'b0, bar_x_q} + STEP9;
      if (right_x9 > X_MAX9) begin
         right_x9 = X_MAX9;
      end
      left_x9 = ({1'b0, bar_x_q} >= STEP9) ? ({1'b0, bar_x_q} - STEP9) : 9'd0;
      new_x   = bar_x_q;
      if (in1_s_q && !in2_s_q) begin
         new_x = right_x9[7:0];
      end else if (in2_s_q && !in1_s_q) begin
         new_x = left_x9[7:0];
      end
   end

   // Row-major advance through the bar rectangle.
   always_comb begin
      rect_last = (px_q == PX_LAST) && (py_q == PY_LAST);
      if (px_q == PX_LAST) begin
         px_adv = '0;
         py_adv = (py_q == PY_LAST) ? '0 : py_q + PYW'(1);
      end else begin
         px_adv = px_q + PXW'(1);
         py_adv = py_q;
      end
   end

   // Next state, counters and the pixel write to register.
   always_comb begin
      state_d = state_q;
      bar_x_d = bar_x_q;
      old_x_d = old_x_q;
      px_d    = px_q;
      py_d    = py_q;
`ifdef BAR_PAINTER_CLEAR_EN
      lin_d   = lin_q;
`endif
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;

      case (state_q)
`ifdef BAR_PAINTER_CLEAR_EN
         ST_CLEAR: begin
            wr_d   = 1'b1;
            addr_d = AW'(lin_q);
            data_d = BG_COLOR;
            if (lin_q == LIN_LAST) begin
               lin_d   = '0;
               state_d = ST_DRAW;
            end else begin
               lin_d = lin_q + LW'(1);
            end
         end
`endif
         ST_ERASE: begin
            wr_d   = 1'b1;
            addr_d = rect_addr(old_x_q, px_q, py_q);
            data_d = BG_COLOR;
            px_d   = px_adv;
            py_d   = py_adv;
            if (rect_last) begin
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            wr_d   = 1'b1;
            addr_d = rect_addr(bar_x_q, px_q, py_q);
            data_d = BAR_COLOR;
            px_d   = px_adv;
            py_d   = py_adv;
            if (rect_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (tick_p && (new_x != bar_x_q)) begin
               old_x_d = bar_x_q;
               bar_x_d = new_x;
               wr_d    = 1'b1;
               addr_d  = rect_addr(bar_x_q, px_q, py_q);
               data_d  = BG_COLOR;
               px_d    = px_adv;
               py_d    = py_adv;
               state_d = rect_last ? ST_DRAW : ST_ERASE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = wr_d || (state_d != ST_IDLE);
   end

   // State, position and pixel counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_START;
         bar_x_q <= X_RST;
         old_x_q <= X_RST;
         px_q    <= '0;
         py_q    <= '0;
`ifdef BAR_PAINTER_CLEAR_EN
         lin_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         bar_x_q <= bar_x_d;
         old_x_q <= old_x_d;
         px_q    <= px_d;
         py_q    <= py_d;
`ifdef BAR_PAINTER_CLEAR_EN
         lin_q   <= lin_d;
`endif
      end
   end

   // Registered write port and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         wr_q   <= wr_d;
         busy_q <= busy_d;
      end
   end

   assign px_if.mem_px_addr = addr_q;
   assign px_if.mem_px_data = data_q;
   assign px_if.px_wr       = wr_q;
   assign busy              = busy_q;

endmodule
